instr_fetch: RTL
================

# instr_fetch

Instruction-fetch stage that produces the instruction and next-PC pair consumed by the IF/ID pipeline register. Owns the program counter, issues word reads to a variable-latency instruction memory with at most one request outstanding, and honours hazard-unit stall and branch redirect/flush. When no valid instruction is available it drives a NOP bubble (instr = 0) into IF/ID.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold fetch outputs and PC
- redirect  in  1  taken branch/jump: flush and load redirect_pc
- redirect_pc  in  32  new fetch target
- imem_req  out  1  one-cycle request strobe
- imem_addr  out  32  byte address of requested word, valid while imem_req=1
- imem_rvalid  in  1  response strobe, ≥1 cycle after imem_req
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- instr  out  32  instruction to IF/ID (0 = bubble)
- npc  out  32  fetched PC + 4 to IF/ID
- valid  out  1  instr/npc carry a real instruction

## Operation
- Registers: pc, state, hold buffer (hold_instr, hold_npc), outputs instr/npc/valid.
- States: ISSUE, WAIT, DROP, HOLD.
- ISSUE: imem_req=1, imem_addr=pc; next WAIT. With redirect: no request, pc←redirect_pc, stay ISSUE.
- WAIT: no rvalid, no redirect → stay. rvalid, no redirect, no stall → outputs←(imem_rdata, pc+4, 1), pc←pc+4, next ISSUE. rvalid, stall → hold buffer←(imem_rdata, pc+4), next HOLD. Redirect without rvalid → pc←redirect_pc, next DROP. Redirect with rvalid → response discarded, pc←redirect_pc, next ISSUE.
- DROP: wait for rvalid, discard it, next ISSUE. Redirect in DROP updates pc, stays DROP (only one response owed).
- HOLD: stall=1 → stay. stall=0 → outputs←hold buffer with valid=1, pc←pc+4, next ISSUE. Redirect → buffer discarded, pc←redirect_pc, next ISSUE.
- Output registers: stall=1 and redirect=0 → hold. stall=0 and no instruction delivered → bubble (instr=0, valid=0, npc held). redirect=1 → bubble regardless of stall (flush beats stall).
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- imem_rvalid outside WAIT/DROP is a protocol error; ignored.

## Timing
- Reset: pc=RESET_PC, state=ISSUE, instr=0, npc=0, valid=0, imem_req=0 in reset cycle, hold buffer=0.
- First imem_req in first cycle after rst deasserts.
- Memory latency L (cycles from req to rvalid): instruction visible at outputs L+1 cycles after req; steady-state throughput one instruction per L+1 cycles.
- Redirect effective next edge; first request to redirect_pc issued in the cycle after the state returns to ISSUE.
- rst mid-transaction: outstanding response is not tracked; memory must be reset concurrently.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]≠0 sets sticky output misalign_err (1 bit, reset 0, cleared only by rst); pc loads {redirect_pc[31:2],2'b00}.
- Undefined: misalign_err port absent; redirect_pc loaded unmodified, low bits appear on imem_addr.

## Structure
- Shared package mips_pkg: NOP_INSTR (32'h0000_0000), PC_STEP (4), fetch state enum.
- One sub-module: pc_reg (PC register with reset-to-RESET_PC, increment, redirect load, hold).

## Test plan
- Reset, memory L=1 returning 32'h2001_0005 @0, 32'h2002_000A @4 → first req addr 0 cycle 1; instr=32'h2001_0005, npc=4, valid=1 cycle 3; second req addr 4 cycle 3.
- stall=1 during rvalid for word @8 (32'hAC01_0000), held 3 cycles → outputs frozen; on release instr=32'hAC01_0000, npc=12 next cycle.
- redirect to 32'h0000_0100 while WAIT with L=3 → bubble (instr=0, valid=0); stale response discarded; next req addr 0x100.
- redirect and stall same cycle in HOLD → bubble, buffer dropped, next req at redirect_pc.
- RESET_PC=32'hFFFF_FFFC → first req 0xFFFF_FFFC, npc=0, next req addr 0.
- FETCH_MISALIGN_CHECK_EN: redirect_pc=32'h0000_0102 → misalign_err=1 sticky, next req addr 0x100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage constants, fetch FSM state encoding and PC step helper.
// Imported by instr_fetch and pc_reg.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_e;

   // Sequential PC; wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: loads RESET_PC on reset, redirect load has priority over increment,
// otherwise holds. pc_plus4_o is the wrapped sequential successor of the current PC.
module pc_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   input  logic        load_i,
   input  logic [31:0] load_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_pc_i;
      end else if (inc_i) begin
         pc_d = pc_next(pc_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_next(pc_q);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, stall hold buffer, redirect flush; drives IF/ID.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misalign_err and word-aligns redirect targets.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] npc,
   output logic        valid
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        misalign_err
`endif
);

   fetch_state_e state_q;
   logic [31:0]  hold_instr_q;
   logic [31:0]  hold_npc_q;
   logic [31:0]  instr_q;
   logic [31:0]  npc_q;
   logic         valid_q;

   logic [31:0]  pc;
   logic [31:0]  pc_plus4;
   logic [31:0]  redirect_tgt;
   logic         deliver_mem;
   logic         deliver_hold;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q;

   assign redirect_tgt = {redirect_pc[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
         misalign_q <= 1'b1;
      end
   end

   assign misalign_err = misalign_q;
`else
   assign redirect_tgt = redirect_pc;
`endif

   // An instruction reaches IF/ID only when neither stall nor flush blocks it.
   assign deliver_mem  = (state_q == ST_WAIT) && imem_rvalid && !redirect && !stall;
   assign deliver_hold = (state_q == ST_HOLD) && !redirect && !stall;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk_i      (clk),
      .rst_i      (rst),
      .inc_i      (deliver_mem || deliver_hold),
      .load_i     (redirect),
      .load_pc_i  (redirect_tgt),
      .pc_o       (pc),
      .pc_plus4_o (pc_plus4)
   );

   assign imem_req  = !rst && (state_q == ST_ISSUE) && !redirect;
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ISSUE;
         hold_instr_q <= NOP_INSTR;
         hold_npc_q   <= '0;
         instr_q      <= NOP_INSTR;
         npc_q        <= '0;
         valid_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_ISSUE: begin
               if (!redirect) begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A redirect without the response still owes one beat, which DROP swallows.
               if (redirect) begin
                  state_q <= imem_rvalid ? ST_ISSUE : ST_DROP;
               end else if (imem_rvalid) begin
                  if (stall) begin
                     hold_instr_q <= imem_rdata;
                     hold_npc_q   <= pc_plus4;
                     state_q      <= ST_HOLD;
                  end else begin
                     state_q <= ST_ISSUE;
                  end
               end
            end
            ST_DROP: begin
               if (imem_rvalid) begin
                  state_q <= ST_ISSUE;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  hold_instr_q <= NOP_INSTR;
                  hold_npc_q   <= '0;
                  state_q      <= ST_ISSUE;
               end else if (!stall) begin
                  state_q <= ST_ISSUE;
               end
            end
            default: begin
               state_q <= ST_ISSUE;
            end
         endcase

         // Flush beats stall; a plain stall freezes the IF/ID outputs.
         if (deliver_mem) begin
            instr_q <= imem_rdata;
            npc_q   <= pc_plus4;
            valid_q <= 1'b1;
         end else if (deliver_hold) begin
            instr_q <= hold_instr_q;
            npc_q   <= hold_npc_q;
            valid_q <= 1'b1;
         end else if (redirect || !stall) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
         end
      end
   end

   assign instr = instr_q;
   assign npc   = npc_q;
   assign valid = valid_q;

endmodule
